// File: rtl/mux_round_robin_seq_if.sv
// Signal bundle for mux_round_robin_seq.
// master = scan controller/consumer side, slave = the mux itself.
//
// Signals:
//   en        scan enable
//   dir       0 = ascending scan, 1 = descending scan
//   ch_mask   per-channel enable, bit i -> channel i
//   in_bus    packed channel data, channel i = in_bus[i*WIDTH +: WIDTH]
//   out       registered selected data
//   out_valid out holds data sampled at the last edge
//   sel       channel index currently being dwelt on
//   wrap      one-cycle pulse when the scan wraps around
interface mux_round_robin_seq_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
);
    logic                    en;
    logic                    dir;
    logic [NUM_CH-1:0]       ch_mask;
    logic [NUM_CH*WIDTH-1:0] in_bus;
    logic [WIDTH-1:0]        out;
    logic                    out_valid;
    logic [SEL_W-1:0]        sel;
    logic                    wrap;

    modport master (
        output en,
        output dir,
        output ch_mask,
        output in_bus,
        input  out,
        input  out_valid,
        input  sel,
        input  wrap
    );

    modport slave (
        input  en,
        input  dir,
        input  ch_mask,
        input  in_bus,
        output out,
        output out_valid,
        output sel,
        output wrap
    );
endinterface

// File: rtl/mux_round_robin_seq.sv
// Round-robin time-multiplexer: registers one of NUM_CH channels per
// dwell period, skipping masked channels, scanning up or down.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active-high, highest priority
//   bus  slave side of mux_round_robin_seq_if
//        (en, dir, ch_mask, in_bus in; out, out_valid, sel, wrap out)
module mux_round_robin_seq #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH),
    parameter int DWELL  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_round_robin_seq_if.slave  bus
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] cur_data;
    logic             cur_en;
    logic [SEL_W-1:0] nxt_sel;
    logic             nxt_wrap;
    logic             advance;

    // Current channel data and enable. A compare-per-channel mux keeps
    // non-power-of-2 NUM_CH free of out-of-range slices.
    always_comb begin
        cur_data = '0;
        cur_en   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_q == SEL_W'(i)) begin
                cur_data = bus.in_bus[i*WIDTH +: WIDTH];
                cur_en   = bus.ch_mask[i];
            end
        end
    end

    // Circular search for the next enabled channel, starting one step
    // away from sel in the scan direction. Step NUM_CH lands back on
    // sel itself, so a lone enabled channel selects itself.
    always_comb begin
        int  idx;
        logic hit;
        logic found;
        idx     = 0;
        hit     = 1'b0;
        found   = 1'b0;
        nxt_sel = sel_q;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (bus.dir) begin
                idx = int'(sel_q) - k;
                if (idx < 0) idx = idx + NUM_CH;
            end else begin
                idx = int'(sel_q) + k;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
            end
            hit = 1'b0;
            for (int j = 0; j < NUM_CH; j++) begin
                if (j == idx) hit = bus.ch_mask[j];
            end
            if (!found && hit) begin
                found   = 1'b1;
                nxt_sel = SEL_W'(idx);
            end
        end
    end

    // Wrap means the new index did not move forward in scan order.
    always_comb begin
        if (bus.dir) nxt_wrap = (nxt_sel >= sel_q);
        else         nxt_wrap = (nxt_sel <= sel_q);
    end

    always_comb begin
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        advance = 1'b0;
        if (bus.en) begin
            if (bus.ch_mask == '0) begin
                cnt_d = '0;
            end else if (cur_en) begin
                out_d   = cur_data;
                valid_d = 1'b1;
                if (cnt_q == CNT_LAST) advance = 1'b1;
                else cnt_d = cnt_q + CNT_W'(1);
            end else begin
                // channel masked off mid-dwell: leave it at once
                advance = 1'b1;
            end
            if (advance) begin
                sel_d  = nxt_sel;
                cnt_d  = '0;
                wrap_d = nxt_wrap;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.sel       = sel_q;
    assign bus.wrap      = wrap_q;

endmodule
